// File: rtl/treasure_map_ctrl_if.sv
// Bundle between level sequencing / player logic and the treasure-layer
// controller. The master side drives load and collect requests; the slave
// side (the controller) returns the live map and status.
interface treasure_map_ctrl_if #(
    parameter int GRID_W = 12,
    parameter int GRID_H = 12,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = $clog2(GRID_W*GRID_H+1)
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    logic [IDX_W-1:0]         Map_Index;
    logic                     Load;
    logic                     Collect_Valid;
    logic [XW-1:0]            Collect_X;
    logic [YW-1:0]            Collect_Y;
    logic [GRID_W*GRID_H-1:0] Treasure_Map_Out;
    logic [CNT_W-1:0]         Remaining;
    logic                     Busy;
    logic                     Collect_Hit;
    logic                     All_Collected;
    logic [15:0]              Score;

    modport master (
        output Map_Index, Load, Collect_Valid, Collect_X, Collect_Y,
        input  Treasure_Map_Out, Remaining, Busy, Collect_Hit, All_Collected, Score
    );

    modport slave (
        input  Map_Index, Load, Collect_Valid, Collect_X, Collect_Y,
        output Treasure_Map_Out, Remaining, Busy, Collect_Hit, All_Collected, Score
    );
endinterface

// File: rtl/treasure_map_ctrl.sv
// Treasure-layer controller: loads a generated treasure bitmap one row per
// clock, clears tiles as the player collects them and tracks the count left.
// Optional feature macro: TREASURE_SCORE_EN (16-bit saturating score counter;
// when undefined Score is tied to zero and no counter flops exist).
//
// state | meaning
// IDLE  | no map loaded since reset
// LOAD  | writing generated rows, one per clock
// READY | map live, collect requests accepted
module treasure_map_ctrl #(
    parameter int GRID_W = 12,
    parameter int GRID_H = 12,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = $clog2(GRID_W*GRID_H+1)
) (
    input  logic                Clk,
    input  logic                Reset,
    treasure_map_ctrl_if.slave  bus
);
    localparam int MAP_W = GRID_W*GRID_H;
    localparam int BIT_W = $clog2(MAP_W);
    localparam int ROW_W = $clog2(GRID_H);

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [ROW_W-1:0] row_q;
    logic [MAP_W-1:0] map_q;
    logic [CNT_W-1:0] remain_q;
    logic             busy_q;
    logic             hit_q;

    logic              in_range;
    logic [BIT_W-1:0]  bit_idx;
    logic [BIT_W-1:0]  row_base;
    logic [GRID_W-1:0] row_bits;
    logic              start_load;
    logic              hit_d;

    // Base layout: treasures three tiles in from each corner, identical for
    // every map index.
    function automatic logic [GRID_W-1:0] gen_row(input logic [ROW_W-1:0] r);
        logic [GRID_W-1:0] row;
        row = '0;
        if (int'(r) == 3 || int'(r) == GRID_H-4) begin
            row[GRID_W-1-3] = 1'b1;
            row[3]          = 1'b1;
        end
        return row;
    endfunction

    // Tile addressing, row generation and request qualification.
    always_comb begin
        in_range   = (int'(bus.Collect_X) < GRID_W) && (int'(bus.Collect_Y) < GRID_H);
        bit_idx    = '0;
        if (in_range) begin
            bit_idx = BIT_W'((GRID_H-1-int'(bus.Collect_Y))*GRID_W + (GRID_W-1-int'(bus.Collect_X)));
        end
        row_base   = BIT_W'((GRID_H-1-int'(row_q))*GRID_W);
        row_bits   = gen_row(row_q);
        start_load = bus.Load && (state_q != LOAD);
        hit_d      = (state_q == READY) && bus.Collect_Valid && !bus.Load &&
                     in_range && map_q[bit_idx];
    end

    // Main FSM: load sequencing, tile clearing and registered status outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            row_q    <= '0;
            map_q    <= '0;
            remain_q <= '0;
            busy_q   <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            if (start_load) begin
                state_q  <= LOAD;
                idx_q    <= bus.Map_Index;
                row_q    <= '0;
                map_q    <= '0;
                remain_q <= '0;
                busy_q   <= 1'b1;
            end else if (state_q == LOAD) begin
                map_q[row_base +: GRID_W] <= row_bits;
                remain_q <= remain_q + CNT_W'($countones(row_bits));
                row_q    <= row_q + 1'b1;
                if (row_q == ROW_W'(GRID_H-1)) begin
                    state_q <= READY;
                    busy_q  <= 1'b0;
                end
            end else if (hit_d) begin
                map_q[bit_idx] <= 1'b0;
                remain_q       <= remain_q - 1'b1;
                hit_q          <= 1'b1;
            end
        end
    end

    // Map_Index is latched for future layout variants; the current generator
    // ignores it, so it is folded into a deliberately unused net.
    logic unused_idx;
    assign unused_idx = ^idx_q;

    assign bus.Treasure_Map_Out = map_q;
    assign bus.Remaining        = remain_q;
    assign bus.Busy             = busy_q;
    assign bus.Collect_Hit      = hit_q;
    assign bus.All_Collected    = (state_q == READY) && (remain_q == '0);

`ifdef TREASURE_SCORE_EN
    logic [15:0] score_q;

    // Score counts every hit, saturates, and survives reloads.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            score_q <= '0;
        end else if (hit_d && (score_q != 16'hFFFF)) begin
            score_q <= score_q + 16'd1;
        end
    end

    assign bus.Score = score_q;
`else
    assign bus.Score = 16'h0000;
`endif
endmodule
